ip_tx_framer: RTL and testbench
===============================

IP_TX_FRAMER -- requirements
Module: ip_tx_framer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: our_ip_address  in  32  source IPv4 address, static during a packet.
REQ-004 SHALL have ports: our_mac_address  in  48  source MAC; dst_mac_address  in  48  next-hop MAC, static during a packet.
REQ-005 SHALL have ports: ip_tx_start  in  1  one-cycle packet request, sampling ip_tx.hdr.
REQ-006 SHALL have ports: ip_tx  in  ipv4_tx_type  hdr{protocol 8, data_length 16, dst_ip_addr 32} plus data{data_out 8, data_out_valid, data_out_last}.
REQ-007 SHALL have ports: ip_tx_result  out  tx_result_type (2)  IDLE/SENDING/ERR/SUCCESS.
REQ-008 SHALL have ports: ip_tx_data_out_ready  out  1  upstream payload byte accepted this cycle when valid.
REQ-009 SHALL have ports: mac_tx_req  out  1  request for MAC channel; mac_tx_granted  in  1  channel grant.
REQ-010 SHALL have ports: mac_data_out  out  8  frame byte; mac_data_out_valid  out  1; mac_data_out_last  out  1  final frame byte; mac_data_out_ready  in  1  MAC accepts byte.
REQ-011 SHALL have parameter: TTL, default 8'd128, IPv4 time-to-live.

Function
REQ-012 SHALL implement an FSM with states IDLE, WAIT_GRANT, SEND_HDR, SEND_DATA, and IDLE as the return state, with each transition on a clk edge.
REQ-013 SHALL, in IDLE, on ip_tx_start=1, latch hdr, compute total_length=data_length+20 (16-bit, wrap ignored), assert mac_tx_req, set result SENDING, and move to WAIT_GRANT.
REQ-014 SHALL ignore ip_tx_start outside IDLE.
REQ-015 SHALL, in WAIT_GRANT, hold mac_tx_req=1 and enter SEND_HDR on mac_tx_granted=1.
REQ-016 SHALL, in SEND_HDR, emit 34 bytes MSB-first, one per cycle with mac_data_out_valid=1, advancing only when mac_data_out_ready=1.
REQ-017 SHALL emit the 34 header bytes in this order: dst MAC, src MAC, 0x0800, 0x45, 0x00, total_length, ident, 0x0000, TTL, protocol, checksum, src IP, dst IP.
REQ-018 SHALL compute the checksum as the ones-complement of the ones-complement 16-bit sum of the ten header words with checksum=0, end-around carries folded, and registered before SEND_HDR begins.
REQ-019 SHALL hold ident as a 16-bit counter, 0 after reset, incremented (wrapping 0xFFFF->0x0000) on each packet completion.
REQ-020 SHALL, in SEND_DATA, drive mac_data_out=ip_tx.data.data_out, mac_data_out_valid=data_out_valid, and ip_tx_data_out_ready=mac_data_out_ready, all combinationally.
REQ-021 SHALL keep ip_tx_data_out_ready=0 in every state other than SEND_DATA.
REQ-022 SHALL count accepted payload bytes and assert mac_data_out_last on byte number data_length.
REQ-023 SHALL, when data_length=0, assert mac_data_out_last on the final header byte and skip SEND_DATA.
REQ-024 SHALL, if upstream data_out_last arrives before count reaches data_length, force mac_data_out_last on that byte, set result ERR, and return to IDLE.
REQ-025 SHALL, if count reaches data_length without upstream last, still end the frame, set result ERR, and return to IDLE.
REQ-026 SHALL, on normal completion, set result SUCCESS, which holds until the next ip_tx_start.
REQ-027 SHALL keep mac_tx_req=1 from WAIT_GRANT through the last accepted byte and drop it the next cycle.
REQ-028 SHALL, if mac_tx_granted drops mid-frame, take no action; grant is only checked in WAIT_GRANT.

Reset
REQ-029 SHALL, on reset=0, immediately drive state IDLE, ident 0, counters 0, ip_tx_result IDLE, and all outputs 0, regardless of packet in progress; no partial last is emitted.

Structure
REQ-030 SHALL take ipv4_tx_type, ipv4_tx_header_type and tx_result_type from global_typs_pkg, and add ETH_HDR_LEN=14, IP_HDR_LEN=20 and ETHERTYPE_IPV4=16'h0800 there.
REQ-031 SHALL place the checksum in sub-module ip_hdr_checksum, a combinational 10-word ones-complement adder with fold.

Verification
REQ-032 SHALL cover: src 192.168.5.9, dst 192.168.5.1, protocol 0x11, data_length 8, ident 0, ready=1 -> 42 bytes out, total_length 0x001C, checksum 0xAF76, last on byte 42, result SUCCESS.
REQ-033 SHALL cover: two back-to-back packets -> second carries ident 0x0001 and its checksum recomputed accordingly.
REQ-034 SHALL cover: mac_data_out_ready toggling 1/0 every cycle during header and data -> byte stream identical to REQ-032, no byte dropped or duplicated.
REQ-035 SHALL cover: data_length 8, upstream last on byte 5 -> mac last on byte 39, result ERR, next start accepted.
REQ-036 SHALL cover: data_length 0 -> 34 bytes, last on byte 34, ip_tx_data_out_ready never asserted.
REQ-037 SHALL cover: reset asserted at byte 20 -> all outputs 0 within the same cycle, result IDLE, a subsequent packet uses ident 0.

Source files
------------

// File: rtl/global_typs_pkg.sv
// Shared IPv4/Ethernet transmit types and framing constants used across the TX datapath.
package global_typs_pkg;

  localparam int          ETH_HDR_LEN    = 14;
  localparam int          IP_HDR_LEN     = 20;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_SENDING = 2'd1,
    TX_ERR     = 2'd2,
    TX_SUCCESS = 2'd3
  } tx_result_type;

  typedef struct packed {
    logic [7:0]  protocol;
    logic [15:0] data_length;
    logic [31:0] dst_ip_addr;
  } ipv4_tx_header_type;

  typedef struct packed {
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_last;
  } ipv4_tx_data_type;

  typedef struct packed {
    ipv4_tx_header_type hdr;
    ipv4_tx_data_type   data;
  } ipv4_tx_type;

endpackage

// File: rtl/ip_hdr_checksum.sv
// Combinational IPv4 header checksum: ones-complement sum of ten 16-bit words, folded, inverted.
module ip_hdr_checksum (
  input  logic [159:0] words,
  output logic [15:0]  checksum
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // 20 bits hold ten 0xFFFF words; two folds are enough to absorb every carry.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) begin
      sum = sum + {4'd0, words[i*16 +: 16]};
    end
    fold1    = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    fold2    = fold1[15:0] + {15'd0, fold1[16]};
    checksum = ~fold2;
  end

endmodule

// File: rtl/ip_tx_framer.sv
// IPv4 transmit framer: prepends Ethernet + IPv4 headers to an upstream payload and streams bytes to the MAC.
module ip_tx_framer
  import global_typs_pkg::*;
#(
  parameter logic [7:0] TTL = 8'd128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   our_ip_address,
  input  logic [47:0]   our_mac_address,
  input  logic [47:0]   dst_mac_address,
  input  logic          ip_tx_start,
  input  ipv4_tx_type   ip_tx,
  output tx_result_type ip_tx_result,
  output logic          ip_tx_data_out_ready,
  output logic          mac_tx_req,
  input  logic          mac_tx_granted,
  output logic [7:0]    mac_data_out,
  output logic          mac_data_out_valid,
  output logic          mac_data_out_last,
  input  logic          mac_data_out_ready,
  output logic [1:0]    fsm_state
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_GRANT = 2'd1;
  localparam logic [1:0] S_SEND_HDR   = 2'd2;
  localparam logic [1:0] S_SEND_DATA  = 2'd3;

  logic [1:0]         state;
  ipv4_tx_header_type hdr_q;
  logic [15:0]        total_len;
  logic [15:0]        ident;
  logic [15:0]        checksum_q;
  logic [15:0]        cksum_comb;
  logic [15:0]        pay_cnt;
  logic [5:0]         hdr_idx;
  logic [159:0]       ip_words;
  logic [271:0]       hdr_vec;
  logic [8:0]         bit_base;
  logic [7:0]         hdr_byte;
  logic               hdr_last;
  logic               pay_end;
  logic               pay_accept;
  logic               up_last;

  assign fsm_state = state;

  // Checksum field is zero while summing.
  assign ip_words = {8'h45, 8'h00, total_len, ident, 16'h0000, TTL, hdr_q.protocol,
                     16'h0000, our_ip_address, hdr_q.dst_ip_addr};

  ip_hdr_checksum u_checksum (
    .words    (ip_words),
    .checksum (cksum_comb)
  );

  assign hdr_vec = {dst_mac_address, our_mac_address, ETHERTYPE_IPV4, 8'h45, 8'h00,
                    total_len, ident, 16'h0000, TTL, hdr_q.protocol, checksum_q,
                    our_ip_address, hdr_q.dst_ip_addr};

  // Byte 0 is the most significant byte of hdr_vec.
  assign bit_base = {6'd33 - hdr_idx, 3'b000};
  assign hdr_byte = hdr_vec[bit_base +: 8];
  assign hdr_last = (hdr_idx == 6'd33);

  assign up_last    = ip_tx.data.data_out_last;
  assign pay_end    = ((pay_cnt + 16'd1) == hdr_q.data_length);
  assign pay_accept = ip_tx.data.data_out_valid && mac_data_out_ready;

  always_comb begin
    mac_tx_req           = (state != S_IDLE);
    mac_data_out         = '0;
    mac_data_out_valid   = 1'b0;
    mac_data_out_last    = 1'b0;
    ip_tx_data_out_ready = 1'b0;
    case (state)
      S_SEND_HDR: begin
        mac_data_out       = hdr_byte;
        mac_data_out_valid = 1'b1;
        mac_data_out_last  = hdr_last && (hdr_q.data_length == 16'd0);
      end
      S_SEND_DATA: begin
        mac_data_out         = ip_tx.data.data_out;
        mac_data_out_valid   = ip_tx.data.data_out_valid;
        mac_data_out_last    = ip_tx.data.data_out_valid && (pay_end || up_last);
        ip_tx_data_out_ready = mac_data_out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      hdr_q        <= '0;
      total_len    <= '0;
      ident        <= '0;
      checksum_q   <= '0;
      pay_cnt      <= '0;
      hdr_idx      <= '0;
      ip_tx_result <= TX_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (ip_tx_start) begin
            hdr_q        <= ip_tx.hdr;
            total_len    <= ip_tx.hdr.data_length + 16'(IP_HDR_LEN);
            hdr_idx      <= '0;
            pay_cnt      <= '0;
            ip_tx_result <= TX_SENDING;
            state        <= S_WAIT_GRANT;
          end
        end
        S_WAIT_GRANT: begin
          // Header fields are stable here, so the registered checksum is valid by SEND_HDR.
          checksum_q <= cksum_comb;
          if (mac_tx_granted) state <= S_SEND_HDR;
        end
        S_SEND_HDR: begin
          if (mac_data_out_ready) begin
            if (hdr_last) begin
              if (hdr_q.data_length == 16'd0) begin
                ident        <= ident + 16'd1;
                ip_tx_result <= TX_SUCCESS;
                state        <= S_IDLE;
              end else begin
                state <= S_SEND_DATA;
              end
            end else begin
              hdr_idx <= hdr_idx + 6'd1;
            end
          end
        end
        S_SEND_DATA: begin
          if (pay_accept) begin
            if (pay_end || up_last) begin
              // Length/last disagreement still closes the frame, but is reported as an error.
              ident        <= ident + 16'd1;
              ip_tx_result <= (pay_end && up_last) ? TX_SUCCESS : TX_ERR;
              state        <= S_IDLE;
            end else begin
              pay_cnt <= pay_cnt + 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_tx_framer.sv
// Randomised bench for ip_tx_framer: frame model feeds an expected-byte queue drained by a monitor.
module tb_ip_tx_framer;
  import global_typs_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   our_ip_address;
  logic [47:0]   our_mac_address;
  logic [47:0]   dst_mac_address;
  logic          ip_tx_start;
  ipv4_tx_type   ip_tx;
  tx_result_type ip_tx_result;
  logic          ip_tx_data_out_ready;
  logic          mac_tx_req;
  logic          mac_tx_granted;
  logic [7:0]    mac_data_out;
  logic          mac_data_out_valid;
  logic          mac_data_out_last;
  logic          mac_data_out_ready;
  logic [1:0]    fsm_state;

  ip_tx_framer #(.TTL(8'd128)) dut (
    .clk                  (clk),
    .reset                (reset),
    .our_ip_address       (our_ip_address),
    .our_mac_address      (our_mac_address),
    .dst_mac_address      (dst_mac_address),
    .ip_tx_start          (ip_tx_start),
    .ip_tx                (ip_tx),
    .ip_tx_result         (ip_tx_result),
    .ip_tx_data_out_ready (ip_tx_data_out_ready),
    .mac_tx_req           (mac_tx_req),
    .mac_tx_granted       (mac_tx_granted),
    .mac_data_out         (mac_data_out),
    .mac_data_out_valid   (mac_data_out_valid),
    .mac_data_out_last    (mac_data_out_last),
    .mac_data_out_ready   (mac_data_out_ready),
    .fsm_state            (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  cap_q[$];
  logic [7:0]  frame_q[$];
  logic [15:0] model_ident;
  logic [8:0]  mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset && mac_data_out_valid && mac_data_out_ready) begin
      cap_q.push_back(mac_data_out);
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {mac_data_out_last, mac_data_out}, 9'h1ff);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_byte", {mac_data_out_last, mac_data_out}, mon_e);
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic add_bytes(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frame_q.push_back(v[i*8 +: 8]);
  endtask

  task automatic build_frame(input logic [15:0] len, input logic [7:0] proto,
                             input logic [31:0] dip, input logic [7:0] pay[$],
                             input int last_pos);
    int          sum;
    int          n_pay;
    logic [15:0] ck;
    frame_q = {};
    add_bytes(dst_mac_address, 6);
    add_bytes(our_mac_address, 6);
    add_bytes(64'h0800, 2);
    add_bytes(64'h45, 1);
    add_bytes(64'h00, 1);
    add_bytes(64'(len + 16'd20), 2);
    add_bytes(64'(model_ident), 2);
    add_bytes(64'h0000, 2);
    add_bytes(64'd128, 1);
    add_bytes(64'(proto), 1);
    add_bytes(64'h0000, 2);
    add_bytes(64'(our_ip_address), 4);
    add_bytes(64'(dip), 4);
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += int'({frame_q[i], frame_q[i+1]});
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = 16'(sum);
    ck = ~ck;
    frame_q[24] = ck[15:8];
    frame_q[25] = ck[7:0];
    n_pay = (last_pos >= 1 && last_pos < int'(len)) ? last_pos : int'(len);
    for (int i = 0; i < n_pay; i++) frame_q.push_back(pay[i]);
  endtask

  // ---------------- driver ----------------
  task automatic run_packet(input logic [15:0] len, input logic [7:0] proto,
                            input logic [31:0] dip, input int last_pos,
                            input int rdy_mode, input int reset_at, input bit glitch);
    logic [7:0]    pay[$];
    int            up_idx, mac_cnt, gdelay, grant_cnt, n_keep;
    bit            done, ready_bad;
    tx_result_type exp_res;
    pay = {};
    for (int i = 0; i < int'(len) + 2; i++) pay.push_back(8'($urandom_range(0, 255)));
    build_frame(len, proto, dip, pay, last_pos);
    exp_q  = {};
    cap_q  = {};
    n_keep = (reset_at > 0) ? reset_at - 1 : frame_q.size();
    for (int i = 0; i < n_keep; i++)
      exp_q.push_back({(i == frame_q.size() - 1) ? 1'b1 : 1'b0, frame_q[i]});
    exp_res = (len == 16'd0 || last_pos == int'(len)) ? TX_SUCCESS : TX_ERR;

    @(posedge clk); #1;
    ip_tx.hdr   = '{protocol: proto, data_length: len, dst_ip_addr: dip};
    ip_tx_start = 1'b1;
    @(posedge clk); #1;
    ip_tx_start = 1'b0;
    @(negedge clk);
    check("req_after_start", mac_tx_req, 1);
    check("result_sending", ip_tx_result, TX_SENDING);

    gdelay = $urandom_range(0, 3);
    grant_cnt = 0; up_idx = 0; mac_cnt = 0; done = 0; ready_bad = 0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(posedge clk); #1;
      if (gdelay > 0) begin
        gdelay--;
        mac_tx_granted = 1'b0;
      end else if (grant_cnt < 2) begin
        mac_tx_granted = 1'b1;
        grant_cnt++;
      end else begin
        mac_tx_granted = 1'b0;
      end
      case (rdy_mode)
        0:       mac_data_out_ready = 1'b1;
        1:       mac_data_out_ready = cyc[0];
        default: mac_data_out_ready = 1'($urandom_range(0, 1));
      endcase
      ip_tx.data.data_out_valid = (up_idx < pay.size()) && (rdy_mode != 2 || $urandom_range(0, 3) != 0);
      ip_tx.data.data_out       = (up_idx < pay.size()) ? pay[up_idx] : 8'h00;
      ip_tx.data.data_out_last  = ip_tx.data.data_out_valid && (up_idx + 1 == last_pos);
      if (glitch && cyc == 10) begin
        ip_tx_start = 1'b1;
        ip_tx.hdr   = '{protocol: 8'h06, data_length: 16'd3, dst_ip_addr: $urandom};
      end else begin
        ip_tx_start = 1'b0;
      end
      if (reset_at > 0 && mac_cnt == reset_at - 1) begin
        reset = 1'b0;
        #1;
        check("reset_outputs", {mac_tx_req, mac_data_out, mac_data_out_valid,
                                mac_data_out_last, ip_tx_data_out_ready}, 0);
        check("reset_result", ip_tx_result, TX_IDLE);
        done = 1;
      end else begin
        @(negedge clk);
        if (mac_cnt < 34 && ip_tx_data_out_ready) ready_bad = 1;
        if (ip_tx.data.data_out_valid && ip_tx_data_out_ready) up_idx++;
        if (mac_data_out_valid && mac_data_out_ready) begin
          mac_cnt++;
          if (mac_data_out_last) done = 1;
        end
      end
    end
    if (!done) check("frame_timeout", 0, 1);

    @(posedge clk); #1;
    ip_tx.data         = '0;
    mac_tx_granted     = 1'b0;
    mac_data_out_ready = 1'b1;
    ip_tx_start        = 1'b0;
    if (reset_at > 0) begin
      check("reset_queue_drained", exp_q.size(), 0);
      reset       = 1'b1;
      model_ident = 16'd0;
      @(negedge clk);
    end else begin
      @(negedge clk);
      check("end_result", ip_tx_result, exp_res);
      check("req_dropped", mac_tx_req, 0);
      check("queue_drained", exp_q.size(), 0);
      check("data_ready_outside_data", ready_bad, 0);
      model_ident = model_ident + 16'd1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset              = 1'b0;
    our_ip_address     = 32'hC0A80509;
    our_mac_address    = 48'h02_12_34_56_78_9A;
    dst_mac_address    = 48'h00_1B_21_AA_BB_CC;
    ip_tx_start        = 1'b0;
    ip_tx              = '0;
    mac_tx_granted     = 1'b0;
    mac_data_out_ready = 1'b0;
    model_ident        = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_outputs", {mac_tx_req, mac_data_out, mac_data_out_valid,
                                  mac_data_out_last, ip_tx_data_out_ready}, 0);
    check("reset_state_result", ip_tx_result, TX_IDLE);
    reset = 1'b1;

    run_packet(16'd8, 8'h11, 32'hC0A80501, 8, 0, 0, 0);
    check("p1_len", cap_q.size(), 42);
    check("p1_total_length", {cap_q[16], cap_q[17]}, 16'h001C);
    check("p1_checksum", {cap_q[24], cap_q[25]}, 16'hAF76);

    run_packet(16'd8, 8'h11, 32'hC0A80501, 8, 0, 0, 0);
    check("p2_ident", {cap_q[18], cap_q[19]}, 16'h0001);
    check("p2_checksum", {cap_q[24], cap_q[25]}, 16'hAF75);

    run_packet(16'd8, 8'h11, 32'hC0A80501, 8, 1, 0, 0);
    check("toggle_len", cap_q.size(), 42);

    run_packet(16'd8, 8'h11, 32'hC0A80501, 5, 0, 0, 0);
    check("early_last_len", cap_q.size(), 39);

    run_packet(16'd8, 8'h11, 32'hC0A80501, 0, 2, 0, 1);
    check("no_last_len", cap_q.size(), 42);

    run_packet(16'd0, 8'h01, 32'hC0A80501, 0, 2, 0, 0);
    check("zero_len", cap_q.size(), 34);

    run_packet(16'd8, 8'h11, 32'hC0A80501, 8, 0, 20, 0);
    check("reset_cut_len", cap_q.size(), 19);

    run_packet(16'd8, 8'h11, 32'hC0A80501, 8, 0, 0, 0);
    check("post_reset_ident", {cap_q[18], cap_q[19]}, 16'h0000);
    check("post_reset_checksum", {cap_q[24], cap_q[25]}, 16'hAF76);

    for (int k = 0; k < 20; k++) begin
      logic [15:0] rl;
      int          lp;
      rl = 16'($urandom_range(0, 40));
      lp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rl) + 1)) : int'(rl);
      run_packet(rl, 8'($urandom_range(0, 255)), $urandom, lp,
                 int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
